// File: rtl/pipe_pkg.sv
// Shared types and defaults for elastic pipeline-stage registers.
package pipe_pkg;

    localparam int unsigned PIPE_DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_slot.sv
// One WIDTH-bit storage slot with load enable; clears to zero on reset.
module skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register: main slot drives the output, skid slot absorbs
// the word that arrives while downstream stalls, so in_ready is a flop.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state;
    skid_state_t      state_nxt;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign main_d   = main_from_skid ? skid_q : in_data;

    // Next-state and slot load decisions; flush overrides every transfer.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    state_nxt = FULL;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
        end
    end

    skid_slot #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (out_data)
    );

    skid_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage at WIDTH 64 and 8 against a two-entry FIFO model.
module tb_pipe_skid_stage;

    logic        clk;
    logic        reset;
    logic        flush64;
    logic        flush8;
    logic        in_valid64;
    logic        in_ready64;
    logic [63:0] in_data64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_data64;
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  out_data8;

    logic [63:0] m64[$];
    logic [7:0]  m8[$];
    logic        last_ix64;
    logic        last_ix8;
    int          pass_cnt;
    int          total_cnt;

    pipe_skid_stage #(.WIDTH(64)) dut64 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush64),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_data   (in_data64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .out_data  (out_data64)
    );

    pipe_skid_stage #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Check outputs against the model, then advance one clock and update it.
    task automatic step();
        logic        ix64;
        logic        ox64;
        logic        ix8;
        logic        ox8;
        logic [63:0] d64;
        logic [7:0]  d8;
        chk("in_ready64", 64'(in_ready64), 64'(m64.size() < 2));
        chk("out_valid64", 64'(out_valid64), 64'(m64.size() != 0));
        if (m64.size() != 0) chk("out_data64", out_data64, m64[0]);
        chk("in_ready8", 64'(in_ready8), 64'(m8.size() < 2));
        chk("out_valid8", 64'(out_valid8), 64'(m8.size() != 0));
        if (m8.size() != 0) chk("out_data8", 64'(out_data8), 64'(m8[0]));
        ix64 = in_valid64 && (m64.size() < 2);
        ox64 = out_ready64 && (m64.size() != 0);
        ix8  = in_valid8 && (m8.size() < 2);
        ox8  = out_ready8 && (m8.size() != 0);
        d64  = in_data64;
        d8   = in_data8;
        @(posedge clk);
        if (!reset || flush64) begin
            m64.delete();
            ix64 = 1'b0;
        end else begin
            if (ox64) void'(m64.pop_front());
            if (ix64) m64.push_back(d64);
        end
        if (!reset || flush8) begin
            m8.delete();
            ix8 = 1'b0;
        end else begin
            if (ox8) void'(m8.pop_front());
            if (ix8) m8.push_back(d8);
        end
        last_ix64 = ix64;
        last_ix8  = ix8;
        @(negedge clk);
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        last_ix64   = 1'b0;
        last_ix8    = 1'b0;
        reset       = 1'b0;
        flush64     = 1'b0;
        flush8      = 1'b0;
        in_valid64  = 1'b0;
        in_data64   = '0;
        out_ready64 = 1'b0;
        in_valid8   = 1'b0;
        in_data8    = '0;
        out_ready8  = 1'b0;
        @(negedge clk);

        // Reset held for two cycles, with handshakes offered and ignored.
        in_valid64  = 1'b1;
        in_data64   = 64'hDEAD;
        out_ready64 = 1'b1;
        chk("rst_out_data64", out_data64, 64'h0);
        chk("rst_out_data8", 64'(out_data8), 64'h0);
        step();
        chk("rst_out_data64_b", out_data64, 64'h0);
        step();
        chk("rst_hold_valid64", 64'(out_valid64), 64'h0);
        chk("rst_hold_ready64", 64'(in_ready64), 64'h1);
        in_valid64 = 1'b0;
        reset      = 1'b1;

        // Pass-through at full rate.
        out_ready64 = 1'b1;
        in_valid64  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data64 = 64'(i);
            step();
            chk("pass_data", out_data64, 64'(i));
        end
        in_valid64 = 1'b0;
        step();
        step();

        // Backpressure fill: A then B, C must wait.
        out_ready64 = 1'b0;
        in_valid64  = 1'b1;
        in_data64   = 64'hA;
        step();
        in_data64 = 64'hB;
        step();
        chk("full_in_ready", 64'(in_ready64), 64'h0);
        chk("full_hold_data", out_data64, 64'hA);
        in_data64 = 64'hC;
        step();
        chk("full_stable_data", out_data64, 64'hA);

        // Drain with C offered until accepted once.
        out_ready64 = 1'b1;
        step();
        chk("drain_b", out_data64, 64'hB);
        step();
        in_valid64 = 1'b0;
        chk("drain_c", out_data64, 64'hC);
        step();
        chk("drain_empty", 64'(out_valid64), 64'h0);
        step();

        // Flush from FULL overrides a concurrent accept and output.
        out_ready64 = 1'b0;
        in_valid64  = 1'b1;
        in_data64   = 64'h11;
        step();
        in_data64 = 64'h12;
        step();
        flush64     = 1'b1;
        in_data64   = 64'hD;
        out_ready64 = 1'b1;
        step();
        flush64    = 1'b0;
        in_valid64 = 1'b0;
        chk("flush_valid", 64'(out_valid64), 64'h0);
        chk("flush_ready", 64'(in_ready64), 64'h1);
        step();
        step();

        // Asynchronous reset between edges while BUSY.
        out_ready64 = 1'b0;
        in_valid64  = 1'b1;
        in_data64   = 64'h21;
        step();
        in_valid64 = 1'b0;
        chk("busy_before_rst", 64'(out_valid64), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid64), 64'h0);
        chk("async_data", out_data64, 64'h0);
        chk("async_ready", 64'(in_ready64), 64'h1);
        m64.delete();
        m8.delete();
        @(negedge clk);
        step();
        reset       = 1'b1;
        out_ready64 = 1'b1;
        in_valid64  = 1'b1;
        in_data64   = 64'h31;
        step();
        in_valid64 = 1'b0;
        chk("post_rst_latency", out_data64, 64'h31);
        step();

        // Random stress on both widths; pending offers are held until taken.
        for (int c = 0; c < 10000; c++) begin
            if (!(in_valid64 && !last_ix64)) begin
                in_valid64 = 1'($urandom_range(0, 1));
                in_data64  = {$urandom, $urandom};
            end
            out_ready64 = 1'($urandom_range(0, 1));
            if (!(in_valid8 && !last_ix8)) begin
                in_valid8 = 1'($urandom_range(0, 1));
                in_data8  = 8'($urandom);
            end
            out_ready8 = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Elastic pipeline-stage register placed between adjacent CPU pipeline stages. It replaces a plain enable-gated register wherever a stage must accept a valid/ready handshake.
- It holds one in-flight word plus one skid word, so upstream sees a registered ready with no combinational ready path across stages.
- It sustains one transfer per cycle with 1-cycle input-to-output latency, and supports a pipeline flush (branch mispredict / exception).

Parameters:
- WIDTH, 64, payload width in bits (PC, instruction, control bundle, etc.).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous, active-high; discards all held words.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept; registered; equals "skid slot empty".
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid word; registered.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  payload from the main slot; registered.

Behaviour:
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready, both sampled at the rising edge of clk.
- Reset (reset = 0, asynchronous):
  - state = EMPTY; out_valid = 0; out_data = 0; skid data = 0; in_ready = 1.
  - While reset is asserted, handshakes are ignored.
  - Reset mid-operation drops all held words and produces no partial output.
- States: EMPTY (no words), BUSY (main slot valid, skid empty), FULL (main and skid valid).
- EMPTY:
  - in_xfer -> main = in_data, go to BUSY.
  - Otherwise stay in EMPTY.
- BUSY:
  - in_xfer & out_xfer -> main = in_data, stay in BUSY (full throughput).
  - in_xfer & !out_xfer -> skid = in_data, go to FULL; in_ready drops to 0 in the next cycle.
  - !in_xfer & out_xfer -> go to EMPTY.
  - Otherwise hold.
- FULL:
  - in_ready = 0, so no in_xfer can occur.
  - out_xfer -> main = skid, go to BUSY; in_ready returns to 1 in the next cycle.
  - Otherwise hold; out_data stays stable while out_valid & !out_ready.
- Ordering: words leave in strict arrival order. No word is duplicated or dropped except by flush or reset.
- Flush:
  - Priority over all transfers in the same cycle: go to EMPTY, out_valid = 0, in_ready = 1 next cycle.
  - A word offered on in_data in the flush cycle is discarded, even if in_valid & in_ready.
  - Data registers need not clear on flush; the valid bits do.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N (visible in cycle N+1). Minimum 1 cycle, maximum unbounded under backpressure.
- Protocol rules:
  - Upstream must hold in_data stable while in_valid & !in_ready (the stage does not check this).
  - out_valid never deasserts without an out_xfer, flush, or reset.
- Invariants:
  - in_ready == (state != FULL).
  - out_valid == (state != EMPTY).
- Width rules: data is passed through unmodified, with no arithmetic; all WIDTH bits are stored.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY, BUSY, FULL};
  - localparam PIPE_DEFAULT_WIDTH = 64.
- Sub-module skid_slot (WIDTH):
  - Contents: a WIDTH-bit data flop bank with load enable, async active-low reset to 0.
  - Instanced twice, as main and skid.
- FSM and handshake logic live in the top module.

Test Plan:
- Reset and pass-through:
  - Stimulus: hold reset = 0 for 2 cycles, release, then drive in_valid = 1 with in_data = 0x1, 0x2, 0x3 on consecutive cycles; out_ready = 1.
  - Required: during reset, out_valid = 0, out_data = 0, in_ready = 1. out_data shows 0x1, 0x2, 0x3 one cycle after each is accepted; in_ready stays 1 throughout.
- Backpressure fill:
  - Stimulus: out_ready = 0; send 0xA then 0xB.
  - Required: out_data = 0xA held stable; in_ready = 0 after 0xB is accepted; 0xC on in_data is not accepted. Raise out_ready: 0xA, then 0xB, then 0xC emerge in order.
- Full drain with concurrent input:
  - Stimulus: in FULL (0xA main, 0xB skid), set out_ready = 1 for 3 cycles with in_valid = 1, in_data = 0xC.
  - Required: output sequence 0xA, 0xB, 0xC; 0xC is accepted only once in_ready returns to 1; no duplicates.
- Flush priority:
  - Stimulus: in FULL, assert flush together with in_valid = 1 (0xD) and out_ready = 1.
  - Required: next cycle out_valid = 0, in_ready = 1, and 0xD never appears on the output.
- Asynchronous reset mid-stream:
  - Stimulus: drop reset between clock edges while in BUSY.
  - Required: out_valid = 0 and out_data = 0 immediately, without waiting for an edge; after release, the first new word has 1-cycle latency.
- Random stress:
  - Stimulus: 10k cycles of random in_valid/out_ready at WIDTH = 64 and WIDTH = 8, no flush.
  - Required: a scoreboard checks in-order, lossless delivery and the invariants on every cycle.
